// File: rtl/alu_exec_unit.sv
// Execute-stage unit: forwarded operand select, single-cycle ALU, iterative multiply.
// Define ALU_DIV_EN to build the iterative unsigned divider (opcodes 11/12).
module alu_exec_unit #(
  parameter int N   = 24,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] aluOut,
  input  logic [N-1:0] result,
  input  logic [3:0]   aluControl,
  input  logic         immSrc,
  input  logic         branchFlag,
  input  logic [1:0]   Fa,
  input  logic [1:0]   Fb,
  output logic         out_valid,
  output logic [N-1:0] aluResult,
  output logic [1:0]   flags,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [SHW:0] NW = (SHW + 1)'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_result;
  logic [1:0]    r_flags;
  logic          r_out_valid;

  logic [N-1:0]  w_op1;
  logic [N-1:0]  w_op2;
  logic [N-1:0]  w_alu_res;
  logic [N-1:0]  w_done_res;
  logic [SHW-1:0] w_amt;
  logic          w_big;
  logic          w_accept;

  assign busy      = (r_state != IDLE);
  assign in_ready  = !busy;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign aluResult = r_result;
  assign flags     = r_flags;

  always_comb begin
    w_op1 = rd1;
    w_op2 = rd2;
    if (branchFlag)      w_op1 = pc;
    else if (Fa == 2'b01) w_op1 = aluOut;
    else if (Fa == 2'b10) w_op1 = result;
    if (immSrc)          w_op2 = imm;
    else if (Fb == 2'b01) w_op2 = aluOut;
    else if (Fb == 2'b10) w_op2 = result;
  end

  assign w_amt = w_op2[SHW-1:0];
  assign w_big = ({1'b0, w_amt} >= NW);

  always_comb begin
    w_alu_res = '0;
    case (aluControl)
      4'd0:  w_alu_res = w_op1 + w_op2;
      4'd1:  w_alu_res = w_op1 - w_op2;
      4'd2:  w_alu_res = w_op1 & w_op2;
      4'd3:  w_alu_res = w_op1 | w_op2;
      4'd4:  w_alu_res = w_op1 ^ w_op2;
      4'd5:  w_alu_res = w_big ? '0 : (w_op1 << w_amt);
      4'd6:  w_alu_res = w_big ? '0 : (w_op1 >> w_amt);
      4'd7:  w_alu_res = w_big ? {N{w_op1[N-1]}} : N'($signed(w_op1) >>> w_amt);
      4'd8:  w_alu_res = {{(N-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      4'd10: w_alu_res = w_op2;
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  // Divider reuses the multiply registers: r_acc = dividend/quotient, r_a = remainder, r_b = divisor.
  logic         r_want_rem;
  logic [N:0]   w_shift;
  logic [N:0]   w_trial;
  assign w_shift    = {r_a, r_acc[N-1]};
  assign w_trial    = w_shift - {1'b0, r_b};
  assign w_done_res = r_want_rem ? r_a : r_acc;
`else
  assign w_done_res = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_flags     <= 2'b01;
      r_out_valid <= 1'b0;
`ifdef ALU_DIV_EN
      r_want_rem  <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (aluControl == 4'd9) begin
              r_state <= MUL;
              r_a     <= w_op1;
              r_b     <= w_op2;
              r_acc   <= '0;
              r_cnt   <= CW'(N);
            end
`ifdef ALU_DIV_EN
            else if (aluControl == 4'd11 || aluControl == 4'd12) begin
              r_want_rem <= (aluControl == 4'd12);
              if (w_op2 == '0) begin
                r_acc   <= '1;
                r_a     <= w_op1;
                r_state <= DONE;
              end else begin
                r_acc   <= w_op1;
                r_a     <= '0;
                r_b     <= w_op2;
                r_cnt   <= CW'(N);
                r_state <= DIV;
              end
            end
`endif
            else begin
              r_result    <= w_alu_res;
              r_flags     <= {w_alu_res[N-1], ~|w_alu_res};
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
`ifdef ALU_DIV_EN
        DIV: begin
          // Borrow out of the trial subtract means the divisor did not fit: restore.
          r_acc <= {r_acc[N-2:0], ~w_trial[N]};
          r_a   <= w_trial[N] ? w_shift[N-1:0] : w_trial[N-1:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
`endif
        DONE: begin
          r_result    <= w_done_res;
          r_flags     <= {w_done_res[N-1], ~|w_done_res};
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
